// File: rtl/pmem_arbiter_if.sv
// Shared bundle between the two cache-controller requesters, the arbiter and the memory port.
// Latency: wires only, no storage.
// Backpressure: none here; completion is signalled per requester by a ready pulse.
interface pmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // requester 0
   logic              req0_valid;
   logic              req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_rdata;
   logic              req0_err;
   // requester 1
   logic              req1_valid;
   logic              req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_rdata;
   logic              req1_err;
   // physical memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   // arbiter view
   modport master (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      output req0_ready, req0_rdata, req0_err,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req1_ready, req1_rdata, req1_err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   // requesters plus memory view
   modport slave (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      input  req0_ready, req0_rdata, req0_err,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req1_ready, req1_rdata, req1_err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between two requesters.
// Latency: mem_req one edge after valid; ready pulse one edge after mem_ready; 3 cycles minimum.
// Backpressure: memory stalls via mem_ready, bounded by TIMEOUT_CYC (0 = unbounded) ending in err.
module pmem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic           clk,
   input  logic           rst,
   pmem_arbiter_if.master bus
);
   localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic              grant;
   logic              last;
   logic [TW-1:0]     tcnt;
   logic [1:0]        valid;
   logic              pick;
   logic              start;
   logic              hit;
   logic              expire;
   logic              finish;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [1:0]        ready;
   logic [1:0]        err;
   logic [DATA_W-1:0] rdata [2];

   assign valid  = {bus.req1_valid, bus.req0_valid};
   assign finish = hit | expire;

   // Next-state and arbitration decision; a lone requester wins, a tie goes to the port not served last
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      hit       = 1'b0;
      expire    = 1'b0;
      pick      = ~last;
      if (valid == 2'b01) begin
         pick = 1'b0;
      end else if (valid == 2'b10) begin
         pick = 1'b1;
      end
      case (state)
         IDLE: begin
            if (|valid) begin
               start     = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            // mem_ready takes priority over a timeout on the same edge
            if (bus.mem_ready) begin
               hit       = 1'b1;
               state_nxt = DONE;
            end else if ((TIMEOUT_CYC != 0) && (tcnt == TLAST)) begin
               expire    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: latch the winner, count stall cycles, and produce the one-cycle completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant     <= 1'b0;
         last      <= 1'b1;
         tcnt      <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ready     <= '0;
         err       <= '0;
         rdata[0]  <= '0;
         rdata[1]  <= '0;
      end else begin
         ready <= '0;
         err   <= '0;
         if (start) begin
            grant     <= pick;
            mem_req   <= 1'b1;
            tcnt      <= '0;
            mem_we    <= pick ? bus.req1_we    : bus.req0_we;
            mem_addr  <= pick ? bus.req1_addr  : bus.req0_addr;
            mem_wdata <= pick ? bus.req1_wdata : bus.req0_wdata;
         end
         if ((state == BUSY) && !finish) begin
            tcnt <= tcnt + TW'(1);
         end
         if (finish) begin
            mem_req      <= 1'b0;
            last         <= grant;
            ready[grant] <= 1'b1;
            err[grant]   <= expire;
            rdata[grant] <= hit ? bus.mem_rdata : '0;
         end
      end
   end

   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];
   assign bus.req0_err   = err[0];
   assign bus.req1_err   = err[1];
   assign bus.req0_rdata = rdata[0];
   assign bus.req1_rdata = rdata[1];
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios followed by random transactions.
// Expected results come from a transaction-level model: winner rule, stall length, response.
// Memory responder and requesters are driven from one initial block.
module tb_pmem_arbiter;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   pmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // transaction-level model state
   logic        m_last;
   logic [31:0] m_rdata [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_ready0"}, 64'(bus.req0_ready), 64'd0);
      chk({tag, "_ready1"}, 64'(bus.req1_ready), 64'd0);
      chk({tag, "_err0"},   64'(bus.req0_err),   64'd0);
      chk({tag, "_err1"},   64'(bus.req1_err),   64'd0);
      chk({tag, "_rdata0"}, 64'(bus.req0_rdata), 64'(m_rdata[0]));
      chk({tag, "_rdata1"}, 64'(bus.req1_rdata), 64'(m_rdata[1]));
   endtask

   // One full transaction, starting and ending at an idle point 1 time unit after a rising edge.
   // lat = BUSY cycle in which memory answers; anything above TO means it never answers.
   task automatic txn(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                      input int lat, input logic [31:0] rd);
      int          w;
      int          n;
      logic        hit;
      logic [31:0] ea, ed;
      logic        ewe;
      w   = (v0 && v1) ? int'(!m_last) : (v1 ? 1 : 0);
      hit = (lat >= 1) && (lat <= TO);
      n   = hit ? lat : TO;
      ea  = (w == 1) ? a1 : a0;
      ed  = (w == 1) ? d1 : d0;
      ewe = (w == 1) ? we1 : we0;
      bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
      bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
      bus.mem_ready  = 1'b0;
      tick;
      for (int k = 1; k <= n; k++) begin
         chk("busy_mem_req",   64'(bus.mem_req),   64'd1);
         chk("busy_mem_addr",  64'(bus.mem_addr),  64'(ea));
         chk("busy_mem_we",    64'(bus.mem_we),    64'(ewe));
         chk("busy_mem_wdata", 64'(bus.mem_wdata), 64'(ed));
         chk("busy_ready0",    64'(bus.req0_ready), 64'd0);
         chk("busy_ready1",    64'(bus.req1_ready), 64'd0);
         // winner withdraws; the loser keeps asking, and neither may disturb the latched request
         if (k == 1) begin
            if (w == 1) bus.req1_valid = 1'b0;
            else        bus.req0_valid = 1'b0;
            bus.req0_addr = $urandom; bus.req1_addr = $urandom;
         end
         bus.mem_ready = (k == lat);
         bus.mem_rdata = (k == lat) ? rd : 32'($urandom);
         tick;
      end
      bus.mem_ready = 1'b0;
      m_rdata[w] = hit ? rd : 32'd0;
      chk("done_mem_req", 64'(bus.mem_req),    64'd0);
      chk("done_ready0",  64'(bus.req0_ready), 64'(w == 0));
      chk("done_ready1",  64'(bus.req1_ready), 64'(w == 1));
      chk("done_err0",    64'(bus.req0_err),   64'(w == 0 && !hit));
      chk("done_err1",    64'(bus.req1_err),   64'(w == 1 && !hit));
      chk("done_rdata0",  64'(bus.req0_rdata), 64'(m_rdata[0]));
      chk("done_rdata1",  64'(bus.req1_rdata), 64'(m_rdata[1]));
      m_last = w[0];
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick;
      chk("idle_mem_req", 64'(bus.mem_req), 64'd0);
      check_quiet("idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic        v0, v1;
      int          sel;
      rst = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
      bus.mem_ready  = 1'b0; bus.mem_rdata = '0;
      m_last = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
      tick; tick;
      chk("rst_mem_req",   64'(bus.mem_req),   64'd0);
      chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
      chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check_quiet("rst");
      rst = 1'b1;
      tick;

      // simultaneous first requests after reset: port 0 first, then port 1
      txn(1'b1, 1'b1, 32'h10, 32'hAAAA_0001, 1'b1, 1'b0, 32'h20, 32'h0, 2, 32'h5555_0000);
      txn(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h20, 32'h0, 1, 32'h0000_0020);

      // single read at 0x40 answered in the third BUSY cycle
      txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'hDEAD_BEEF);

      // continuous contention: strict alternation
      for (int i = 0; i < 6; i++) begin
         txn(1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 1'b1, 1'b1, 32'h200 + 32'(i), 32'hC0DE_0000 + 32'(i),
             1 + (i % 3), 32'hF00D_0000 + 32'(i));
      end

      // timeout on port 1: memory never answers
      txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 99, 32'hBAD0_BAD0);

      // memory answers on the timeout edge: data wins, no error
      txn(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, TO, 32'h0000_1234);

      // reset during the second BUSY cycle
      bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 32'h80; bus.req0_wdata = 32'h77;
      tick;
      bus.req0_valid = 1'b0;
      tick;
      chk("pre_rst_mem_req", 64'(bus.mem_req), 64'd1);
      rst = 1'b0;
      #1;
      m_last = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
      chk("arst_mem_req",  64'(bus.mem_req),  64'd0);
      chk("arst_mem_we",   64'(bus.mem_we),   64'd0);
      chk("arst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check_quiet("arst");
      bus.mem_ready = 1'b1;
      tick;
      check_quiet("arst_hold");
      bus.mem_ready = 1'b0;
      rst = 1'b1;
      tick;
      txn(1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 2, 32'h1111_2222);

      // random traffic, with mem_ready noise while idle
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(1, 3);
         v0  = sel[0];
         v1  = sel[1];
         txn(v0, 1'($urandom), $urandom, $urandom, v1, 1'($urandom), $urandom, $urandom,
             $urandom_range(1, TO + 2), $urandom);
         repeat ($urandom_range(0, 2)) begin
            bus.mem_ready = 1'($urandom);
            bus.mem_rdata = $urandom;
            tick;
            chk("gap_mem_req", 64'(bus.mem_req), 64'd0);
            check_quiet("gap");
         end
         bus.mem_ready = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port arbiter sharing the single physical-memory port between two cache controllers (e.g. instruction and data). Each requester issues one read or write transaction at a time. The block grants the memory round-robin, latches the winning request, and holds the memory request until the memory acknowledges. It then returns read data to the winner, and ends with an error if the memory stalls past a timeout. It sits between the cache controllers and the physical memory model on the shared memory interface.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 64, maximum cycles a request may wait for mem_ready; 0 disables the timeout

Ports (N = 0, 1 for the requester ports):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- reqN_valid  in  1  requester N has a transaction pending
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  transaction address
- reqN_wdata  in  DATA_W  write data
- reqN_ready  out  1  one-cycle completion pulse to requester N
- reqN_rdata  out  DATA_W  read data; valid while reqN_ready is high, held afterwards
- reqN_err  out  1  completion was a timeout; valid with reqN_ready
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory acknowledge; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY, DONE.
- Registers: grant (0/1), last (last served port), tcnt (width $clog2(TIMEOUT_CYC+1), minimum 1).
- Reset (rst low):
  - state = IDLE, last = 1.
  - All outputs 0; the mem_* and reqN_* registers are cleared.
  - A reset in BUSY abandons the transaction; no ready pulse is issued.
- IDLE:
  - If exactly one reqN_valid is high, grant that port.
  - If both are high, grant the port not equal to last.
  - On a grant:
    - latch reqN_we/addr/wdata into the mem_* registers
    - set mem_req = 1 and tcnt = 0
    - go to BUSY.
  - mem_ready is ignored in IDLE.
- BUSY:
  - mem_req stays high; mem_we/addr/wdata stay stable; requester inputs are ignored.
  - If mem_ready is high:
    - capture mem_rdata into req[grant]_rdata (also on writes)
    - set req[grant]_ready = 1 and req[grant]_err = 0
    - set mem_req = 0 and last = grant
    - go to DONE.
  - Else, if TIMEOUT_CYC != 0 and tcnt == TIMEOUT_CYC-1:
    - set req[grant]_rdata = 0, req[grant]_err = 1, req[grant]_ready = 1
    - set mem_req = 0 and last = grant
    - go to DONE.
  - Else tcnt increments.
  - If mem_ready arrives on the timeout edge, mem_ready wins and err = 0.
- DONE:
  - The ready (and err) outputs are high for exactly this one cycle, then clear.
  - Go to IDLE.
  - A requester must drop valid in the DONE cycle. If valid is still high in IDLE, it is treated as a new transaction.
- Only one reqN_ready is ever high at a time; the non-granted port's outputs do not change.

## Timing
- Valid high before edge E0: mem_req is high after E0.
- mem_ready high before edge Ek: reqN_ready is high for the cycle after Ek; mem_req is low after Ek.
- The next grant is sampled at Ek+2.
- Minimum occupancy is 3 cycles per transaction (mem_ready on the first BUSY cycle).
- Timeout: mem_req is high for exactly TIMEOUT_CYC cycles; the err pulse follows in the next cycle.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.

## Test plan
- Single read: req0 reads addr 0x40; memory answers after 3 cycles with 0xDEADBEEF.
  - mem_req is high 3 cycles with mem_addr = 0x40 and mem_we = 0.
  - req0_ready pulses once with rdata = 0xDEADBEEF and err = 0.
- Simultaneous first requests after reset: req0 writes 0x10 and req1 reads 0x20.
  - Port 0 is served first (mem_we = 1, mem_addr = 0x10), then port 1 (mem_addr = 0x20).
- Continuous contention: both valids held high for 6 transactions.
  - Grant order is 0,1,0,1,0,1.
  - Latched mem_addr matches each winner's address.
- Timeout: TIMEOUT_CYC = 4; req1 requests and mem_ready is never asserted.
  - mem_req is high exactly 4 cycles.
  - req1_ready pulses with err = 1 and rdata = 0; the block returns to IDLE.
- Ready on the timeout edge: TIMEOUT_CYC = 4; mem_ready arrives in the 4th BUSY cycle with data 0x1234.
  - req_ready pulses with rdata = 0x1234 and err = 0.
- Reset mid-BUSY: rst pulled low during the 2nd BUSY cycle.
  - All outputs go to 0 immediately (asynchronous); no ready pulse is issued.
  - After release, both valids high: port 0 is granted first.
